noc_fifo_wr_sched: RTL and testbench

Single-clock write scheduler and pointer controller for the shared flit buffer memory (`fifomem`) in a NoC output queue. It arbitrates round-robin among NREQ requesters and holds the grant for the full length of a multi-flit (wormhole) packet. It drives the memory's write enable, write address and write data, and owns the read pointer and the full/empty/count status. The memory itself is instantiated next to this block in the queue wrapper, not inside it.

---
 rtl/noc_fifo_pkg.sv | 18 +
 rtl/noc_fifo_wr_sched_rr_arbiter.sv | 35 +++
 rtl/noc_fifo_wr_sched.sv | 123 ++++++++++++
 tb/tb_noc_fifo_wr_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fifo_pkg.sv
// Shared types and constants for the NoC output-queue write scheduler.
package noc_fifo_pkg;

  // Arbiter FSM: IDLE picks a new winner, LOCKED holds a wormhole packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Default flit width.
  localparam int DEF_LENGTH = 32;

  // Pointer width: slot address bits plus one wrap bit.
  function automatic int ptr_width(input int msb_slot);
    return msb_slot + 2;
  endfunction

endpackage

// File: rtl/noc_fifo_wr_sched_rr_arbiter.sv
// Combinational cyclic priority picker: first active request at or after rr_ptr_i.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  int            j;
  logic [IW-1:0] jj;

  // Walk all requesters starting at rr_ptr_i, wrapping past NREQ-1.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/noc_fifo_wr_sched.sv
// Write scheduler and pointer controller for the shared flit buffer of a
// NoC output queue: round-robin arbitration with wormhole packet locking,
// memory write port drive, read pointer and full/empty/count status.
module noc_fifo_wr_sched
  import noc_fifo_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LENGTH   = DEF_LENGTH,
  parameter int DEPTH    = 32,
  parameter int MSB_SLOT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*LENGTH-1:0]   req_data,
  output logic [NREQ-1:0]          grant,
  input  logic                     rd_en,
  output logic                     rempty,
  output logic                     wfull,
  output logic [MSB_SLOT+1:0]      count,
  output logic                     mem_wclken,
  output logic [MSB_SLOT:0]        mem_waddr,
  output logic [LENGTH-1:0]        mem_wdata,
  output logic [MSB_SLOT:0]        mem_raddr
);

  localparam int PW = ptr_width(MSB_SLOT);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(DEPTH);

  state_e        state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     next_idx;
  logic              win_last;
  logic              wr_go;
  logic              rd_go;
  logic [LENGTH-1:0] flit [NREQ];

  // Unpack the flat data bus into one flit per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_flit
      assign flit[gi] = req_data[gi*LENGTH +: LENGTH];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx)
  );

  // Grant: fresh round-robin pick when idle, owner only while locked; never when full or in reset.
  always_comb begin
    grant   = '0;
    win_idx = (state_q == LOCKED) ? owner_q : arb_idx;
    if (!rst && !wfull) begin
      if (state_q == IDLE) begin
        grant = arb_gnt;
      end else begin
        grant[owner_q] = req[owner_q];
      end
    end
  end

  assign wr_go    = |grant;
  assign win_last = req_last[win_idx];
  assign next_idx = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign rd_go    = rd_en & ~rempty;

  assign mem_wclken = wr_go;
  assign mem_wdata  = wr_go ? flit[win_idx] : '0;
  assign mem_waddr  = wptr_q[AW-1:0];
  assign mem_raddr  = rptr_q[AW-1:0];

  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[PW-2:0] == rptr_q[PW-2:0]) && (wptr_q[PW-1] != rptr_q[PW-1]);
  assign count  = wptr_q - rptr_q;

  // Packet lock FSM: a non-last flit locks the winner until its last flit is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (wr_go) begin
      if (state_q == IDLE) begin
        if (win_last) begin
          rr_ptr_q <= next_idx;
        end else begin
          state_q <= LOCKED;
          owner_q <= win_idx;
        end
      end else if (win_last) begin
        state_q  <= IDLE;
        rr_ptr_q <= next_idx;
      end
    end
  end

  // Write pointer advances per accepted flit; read pointer per pop of a non-empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_go) wptr_q <= wptr_q + 1'b1;
      if (rd_go) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_fifo_wr_sched.sv
// Randomized bench for noc_fifo_wr_sched against a queue-based reference model.
module tb_noc_fifo_wr_sched;

  localparam int NREQ  = 4;
  localparam int LEN   = 32;
  localparam int DEPTH = 32;
  localparam int MSB   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*LEN-1:0]  req_data;
  logic [NREQ-1:0]      grant;
  logic                 rd_en;
  logic                 rempty;
  logic                 wfull;
  logic [MSB+1:0]       count;
  logic                 mem_wclken;
  logic [MSB:0]         mem_waddr;
  logic [LEN-1:0]       mem_wdata;
  logic [MSB:0]         mem_raddr;

  noc_fifo_wr_sched #(
    .NREQ(NREQ), .LENGTH(LEN), .DEPTH(DEPTH), .MSB_SLOT(MSB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .grant(grant), .rd_en(rd_en), .rempty(rempty), .wfull(wfull), .count(count),
    .mem_wclken(mem_wclken), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr)
  );

  always #5 clk = ~clk;

  // Flit memory that sits next to the scheduler in the queue wrapper.
  logic [LEN-1:0] tb_mem [DEPTH];
  always @(posedge clk) if (mem_wclken) tb_mem[mem_waddr] <= mem_wdata;

  // Reference model state.
  logic [LEN-1:0] q[$];
  int own = -1;
  int rr  = 0;
  int nwr = 0;
  int nrd = 0;

  // Producers: flits left in current packet and current flit data.
  int             rem [NREQ];
  logic [LEN-1:0] dat [NREQ];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int model_winner();
    if (q.size() >= DEPTH) return -1;
    if (own >= 0) return req[own] ? own : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive(input int p_new, input int maxlen, input int p_hold, input int p_rd);
    for (int i = 0; i < NREQ; i++) begin
      if (rem[i] == 0 && int'($urandom_range(99, 0)) < p_new) begin
        rem[i] = int'($urandom_range(maxlen, 1));
        dat[i] = $urandom;
      end
      req[i]      = (rem[i] > 0) && (int'($urandom_range(99, 0)) < p_hold);
      req_last[i] = (rem[i] == 1);
      req_data[i*LEN +: LEN] = dat[i];
    end
    rd_en = int'($urandom_range(99, 0)) < p_rd;
  endtask

  task automatic check_outputs(input int w);
    logic [NREQ-1:0] eg;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("grant", grant, eg);
    chk("wclken", mem_wclken, (w >= 0));
    chk("wdata", mem_wdata, (w >= 0) ? dat[w] : '0);
    chk("waddr", mem_waddr, nwr % DEPTH);
    chk("raddr", mem_raddr, nrd % DEPTH);
    chk("rempty", rempty, (q.size() == 0));
    chk("wfull", wfull, (q.size() == DEPTH));
    chk("count", count, q.size());
    if (q.size() > 0) chk("head", tb_mem[mem_raddr], q[0]);
  endtask

  task automatic commit(input int w);
    if (rd_en && q.size() > 0) begin
      void'(q.pop_front());
      nrd++;
    end
    if (w >= 0) begin
      q.push_back(dat[w]);
      nwr++;
      if (own < 0) begin
        if (req_last[w]) rr = (w + 1) % NREQ;
        else own = w;
      end else if (req_last[w]) begin
        own = -1;
        rr  = (w + 1) % NREQ;
      end
      rem[w]--;
      dat[w] = $urandom;
    end
  endtask

  task automatic model_reset();
    q.delete();
    own = -1; rr = 0; nwr = 0; nrd = 0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
  endtask

  task automatic step(input int p_new, input int maxlen, input int p_hold, input int p_rd);
    int w;
    @(negedge clk);
    drive(p_new, maxlen, p_hold, p_rd);
    #1;
    w = model_winner();
    check_outputs(w);
    @(posedge clk);
    commit(w);
  endtask

  task automatic run(input int n, input int p_new, input int maxlen, input int p_hold, input int p_rd);
    for (int c = 0; c < n; c++) step(p_new, maxlen, p_hold, p_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; rd_en = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rempty", rempty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_grant", grant, 0);
    #2 rst = 1'b0;

    // Single-flit packet on requester 2.
    rem[2] = 1; dat[2] = 32'hA5A5_0001;
    @(negedge clk);
    drive(0, 1, 100, 0);
    #1;
    chk("t1_grant", grant, 4'b0100);
    chk("t1_waddr", mem_waddr, 0);
    chk("t1_wdata", mem_wdata, 32'hA5A5_0001);
    check_outputs(model_winner());
    @(posedge clk);
    commit(model_winner());
    #1;
    chk("t1_rempty", rempty, 1'b0);
    chk("t1_count", count, 1);

    // All requesters streaming single-flit packets: rotation.
    run(12, 100, 1, 100, 100);
    // Multi-flit packets with competition and bubbles.
    run(60, 80, 4, 85, 50);
    // Fill to full with no reads.
    run(45, 100, 3, 100, 0);
    #1;
    chk("full_wfull", wfull, 1'b1);
    chk("full_count", count, DEPTH);
    chk("full_grant", grant, 0);
    // Pop in the full cycle, then grant resumes the cycle after.
    step(100, 3, 100, 100);
    step(100, 3, 100, 0);
    // Concurrent traffic with wrap-around, then read-heavy to hit empty.
    run(300, 70, 4, 85, 70);
    run(100, 40, 3, 70, 95);

    // Reach a locked packet, then reset mid-packet.
    for (int c = 0; c < 200 && own < 0; c++) step(100, 4, 100, 30);
    chk("lock_seen", (own >= 0), 1'b1);
    @(negedge clk);
    drive(0, 1, 100, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_wclken", mem_wclken, 1'b0);
    chk("mid_rst_rempty", rempty, 1'b1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_waddr", mem_waddr, 0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;

    // After release every requester asks: requester 0 wins first.
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1;
      dat[i] = $urandom;
    end
    @(negedge clk);
    drive(0, 1, 100, 0);
    #1;
    chk("restart_grant", grant, 4'b0001);
    check_outputs(model_winner());
    @(posedge clk);
    commit(model_winner());
    run(100, 60, 4, 80, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
